// File: rtl/sag_seq.sv
// Bit-serial sheep-and-goats engine: one data bit per clock, SAG in one pass,
// non-reversing SAG as two chained passes (data pass, then re-SAG by compressed control).
module sag_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_mode_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [WIDTH-1:0] in_ctrl_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [WIDTH-1:0] out_ctrl_o,
  output logic             busy_o
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StDone} state_e;

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] d_q, d_d, c_q, c_d;
  logic [WIDTH-1:0] res_q, res_d, cres_q, cres_d;
  logic [WIDTH-1:0] out_data_q, out_data_d, out_ctrl_q, out_ctrl_d;
  logic [IW-1:0]    i_q, i_d, j_q, j_d, k_q, k_d;

  logic             cur_bit, cur_ctl, last;
  logic [WIDTH-1:0] res_step, cres_step;

  always_comb begin
    cur_bit   = d_q[i_q];
    cur_ctl   = c_q[i_q];
    last      = (i_q == LastIdx);
    res_step  = res_q;
    cres_step = cres_q;
    // Ones fill upward from the LSB, zeros fill downward from the MSB.
    if (cur_ctl) begin
      res_step[j_q]  = cur_bit;
      cres_step[j_q] = 1'b1;
    end else begin
      res_step[k_q]  = cur_bit;
      cres_step[k_q] = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    d_d        = d_q;
    c_d        = c_q;
    res_d      = res_q;
    cres_d     = cres_q;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;

    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            mode_d  = in_mode_i;
            d_d     = in_data_i;
            c_d     = in_ctrl_i;
            res_d   = '0;
            cres_d  = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = LastIdx;
            state_d = StPass1;
          end
        end
        StPass1, StPass2: begin
          res_d = res_step;
          if (state_q == StPass1) cres_d = cres_step;
          i_d = i_q + IW'(1);
          // Pointers hold on the final bit so they never leave [0, WIDTH-1].
          if (!last && cur_ctl)  j_d = j_q + IW'(1);
          if (!last && !cur_ctl) k_d = k_q - IW'(1);
          if (last) begin
            i_d = '0;
            j_d = '0;
            k_d = LastIdx;
            if (state_q == StPass1 && mode_q) begin
              d_d     = res_step;
              c_d     = cres_step;
              res_d   = '0;
              state_d = StPass2;
            end else begin
              out_data_d = res_step;
              out_ctrl_d = (state_q == StPass1) ? cres_step : cres_q;
              state_d    = StDone;
            end
          end
        end
        StDone: begin
          if (out_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      mode_q     <= 1'b0;
      d_q        <= '0;
      c_q        <= '0;
      res_q      <= '0;
      cres_q     <= '0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      d_q        <= d_d;
      c_q        <= c_d;
      res_q      <= res_d;
      cres_q     <= cres_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StPass1) || (state_q == StPass2);
  assign out_data_o  = out_data_q;
  assign out_ctrl_o  = out_ctrl_q;

endmodule

// File: tb/tb_sag_seq.sv
// Self-checking bench for sag_seq: directed cases plus random requests
// compared against a queue-based sheep-and-goats reference.
module tb_sag_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = $clog2(W);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] in_ctrl = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [W-1:0] out_ctrl;
  logic         busy;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sag_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_mode_i   (in_mode),
    .in_data_i   (in_data),
    .in_ctrl_i   (in_ctrl),
    .flush_i     (flush),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ctrl_o  (out_ctrl),
    .busy_o      (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bits with mask=1 packed from the LSB in order; mask=0 bits packed from the MSB.
  function automatic logic [W-1:0] sag_ref(input logic [W-1:0] x, input logic [W-1:0] m);
    bit q1[$];
    bit q0[$];
    logic [W-1:0] r;
    for (int n = 0; n < W; n++) begin
      if (m[n]) q1.push_back(x[n]);
      else      q0.push_back(x[n]);
    end
    r = '0;
    foreach (q1[p]) r[p] = q1[p];
    foreach (q0[p]) r[W-1-p] = q0[p];
    return r;
  endfunction

  function automatic logic [W-1:0] model(input bit mode, input logic [W-1:0] ci,
                                          input logic [W-1:0] di);
    if (mode) return sag_ref(sag_ref(di, ci), sag_ref(ci, ci));
    return sag_ref(di, ci);
  endfunction

  always @(negedge clk) begin
    if (!rst && busy && dut.i_q == IW'(W - 1)) check_eq("j_eq_k", 32'(dut.j_q), 32'(dut.k_q));
  end

  task automatic send(input bit mode, input logic [W-1:0] ci, input logic [W-1:0] di);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check_eq("in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_mode = mode; in_ctrl = ci; in_data = di;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_ctrl  = W'($urandom);
    in_mode  = ~mode;
  endtask

  // Call right after the accept edge (+1).
  task automatic collect(input bit mode, input logic [W-1:0] ci, input logic [W-1:0] di,
                         input int hold);
    logic [W-1:0] ed;
    int n = 0;
    ed = model(mode, ci, di);
    while (!out_valid && n < 4 * W) begin
      @(posedge clk); #1; n++;
    end
    check_eq("latency", 32'(n), mode ? 32'(2 * W) : 32'(W));
    check_eq("out_data", 32'(out_data), 32'(ed));
    check_eq("out_ctrl", 32'(out_ctrl), 32'(sag_ref(ci, ci)));
    check_eq("busy_done", 32'(busy), 32'd0);
    check_eq("in_ready_done", 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_data", 32'(out_data), 32'(ed));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("valid_drop", 32'(out_valid), 32'd0);
    check_eq("idle_keep", 32'(out_data), 32'(ed));
  endtask

  task automatic do_op(input bit mode, input logic [W-1:0] ci, input logic [W-1:0] di,
                       input int hold);
    send(mode, ci, di);
    collect(mode, ci, di, hold);
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_ctrl", 32'(out_ctrl), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-answer cases.
    do_op(1'b0, 8'h0F, 8'hA5, 0);
    check_eq("kat_sag", 32'(out_data), 32'h55);
    do_op(1'b1, 8'h0F, 8'hA5, 0);
    check_eq("kat_nrsag", 32'(out_data), 32'hA5);
    do_op(1'b0, 8'h00, 8'h01, 0);
    check_eq("kat_sag_00", 32'(out_data), 32'h80);
    do_op(1'b1, 8'h00, 8'h01, 1);
    check_eq("kat_nrsag_00", 32'(out_data), 32'h01);
    do_op(1'b0, 8'hFF, 8'h3C, 0);
    check_eq("kat_sag_ff", 32'(out_data), 32'h3C);

    // Backpressure with a request already pending on in_valid.
    send(1'b0, 8'h0F, 8'hA5);
    repeat (W) begin @(posedge clk); #1; end
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b1; in_mode = 1'b0; in_ctrl = 8'h00; in_data = 8'h01;
    repeat (5) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_data", 32'(out_data), 32'h55);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_no_accept", 32'(busy), 32'd0);
    check_eq("bp_idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_accept", 32'(busy), 32'd1);
    collect(1'b0, 8'h00, 8'h01, 0);

    // Flush in PASS1 at i=3.
    send(1'b0, 8'h5A, 8'hC3);
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", 32'(busy), 32'd0);
    check_eq("flush_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (2 * W) begin @(posedge clk); #1; if (out_valid) seen++; end
    check_eq("flush_no_out", 32'(seen), 32'd0);
    do_op(1'b1, 8'h5A, 8'hC3, 0);
    // flush wins over in_valid in IDLE.
    in_valid = 1'b1; flush = 1'b1; in_ctrl = 8'h12; in_data = 8'h34;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle_busy", 32'(busy), 32'd0);
    check_eq("flush_idle_ready", 32'(in_ready), 32'd1);

    // Random requests in both modes with occasional backpressure.
    for (int t = 0; t < 1200; t++) begin
      do_op(1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
    end

    // Asynchronous reset in the middle of PASS2.
    send(1'b1, 8'h96, 8'h3B);
    repeat (W + 2) begin @(posedge clk); #1; end
    check_eq("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_out_data", 32'(out_data), 32'd0);
    check_eq("arst_out_ctrl", 32'(out_ctrl), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    repeat (3 * W) begin @(posedge clk); #1; if (out_valid) seen++; end
    check_eq("arst_no_out", 32'(seen), 32'd0);
    do_op(1'b0, 8'h0F, 8'hA5, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
